// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one ROM read per cycle into a 2-entry
// {instr, pc} FIFO, accounting for the in-flight read so the FIFO never overflows.
module fetch_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        flush,
  input  logic [7:0]  pc_in,
  output logic        pc_enable,
  output logic [7:0]  pc_increment,
  output logic        mem_req,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_data,
  output logic [15:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        out_ready,
  output logic        busy
);

  logic [1:0]  count;
  logic        inflight;
  logic [7:0]  tag;
  logic [15:0] data0, data1;
  logic [7:0]  addr0, addr1;
  logic        pop, push, issue;
  logic [2:0]  occupancy;

  assign instr_valid = (count != 2'd0);
  assign pop         = instr_valid & out_ready;
  assign push        = inflight & ~flush;
  assign occupancy   = {1'b0, count} - {2'b00, pop} + {2'b00, inflight};

  // Reset gates issue so the strobes drop the moment reset is asserted.
  assign issue = reset & enable & ~flush & (occupancy < 3'd2);

  assign mem_req      = issue;
  assign pc_enable    = issue;
  assign pc_increment = issue ? 8'd1 : 8'd0;
  assign mem_addr     = issue ? pc_in : 8'd0;

  assign instr    = data0;
  assign instr_pc = addr0;
  assign busy     = inflight | instr_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= 2'd0;
      inflight <= 1'b0;
      tag      <= 8'd0;
      data0    <= 16'd0;
      data1    <= 16'd0;
      addr0    <= 8'd0;
      addr1    <= 8'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag <= pc_in;
      end
      if (flush) begin
        count <= 2'd0;
      end else begin
        // Entry 0 is always the head; entry 1 shifts down on a pop.
        case ({push, pop})
          2'b10: begin
            if (count == 2'd0) begin
              data0 <= mem_data;
              addr0 <= tag;
              count <= count + 2'd1;
            end else if (count == 2'd1) begin
              data1 <= mem_data;
              addr1 <= tag;
              count <= count + 2'd1;
            end
          end
          2'b01: begin
            data0 <= data1;
            addr0 <= addr1;
            count <= count - 2'd1;
          end
          2'b11: begin
            if (count == 2'd1) begin
              data0 <= mem_data;
              addr0 <= tag;
            end else begin
              data0 <= data1;
              addr0 <= addr1;
              data1 <= mem_data;
              addr1 <= tag;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a program counter and a synchronous ROM
// (ROM[a] = 16'hA000 + a) modelled around it.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        flush;
  logic [7:0]  pc_in;
  logic        pc_enable;
  logic [7:0]  pc_increment;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic [15:0] mem_data;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        out_ready;
  logic        busy;

  logic        pc_load;
  logic [7:0]  pc_load_val;
  logic [7:0]  pc;

  logic [23:0] sb[$];
  int          n_compared;
  int          n_mismatched;

  fetch_unit dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .flush(flush),
    .pc_in(pc_in),
    .pc_enable(pc_enable),
    .pc_increment(pc_increment),
    .mem_req(mem_req),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .out_ready(out_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign pc_in = pc;

  always @(posedge clk or negedge reset) begin
    if (!reset)           pc <= 8'd0;
    else if (pc_load)     pc <= pc_load_val;
    else if (pc_enable)   pc <= pc + pc_increment;
  end

  // Idle cycles return a marker value so a mistimed push is visible.
  always @(posedge clk) begin
    if (mem_req) mem_data <= 16'hA000 + {8'h00, mem_addr};
    else         mem_data <= 16'hDEAD;
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && instr_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL unexpected_pop: got %0h/%0h, expected nothing", instr, instr_pc);
      end else begin
        check_output("head_entry", {8'h00, instr, instr_pc}, {8'h00, sb.pop_front()});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int cycles;
    cycles = 0;
    while ((sb.size() != 0 || busy) && cycles < 30) begin
      next_cycle();
      cycles++;
    end
    check_output({name, "_drain"}, {31'd0, (sb.size() == 0 && !busy)}, 32'd1);
  endtask

  task automatic apply_reset();
    enable = 1'b0; flush = 1'b0; out_ready = 1'b0;
    reset = 1'b0;
    repeat (2) next_cycle();
    reset = 1'b1;
  endtask

  initial begin
    n_compared = 0;
    n_mismatched = 0;
    reset = 1'b1; enable = 1'b1; flush = 1'b0; out_ready = 1'b1;
    pc_load = 1'b0; pc_load_val = 8'd0;

    // Reset state, with enable high to show the strobes are held off.
    #1 reset = 1'b0;
    #2;
    check_output("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_output("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check_output("rst_pc_enable", {31'd0, pc_enable}, 32'd0);
    check_output("rst_pc_increment", {24'd0, pc_increment}, 32'd0);
    check_output("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    check_output("rst_instr", {16'd0, instr}, 32'd0);
    check_output("rst_instr_pc", {24'd0, instr_pc}, 32'd0);

    // Streaming: one instruction per cycle.
    apply_reset();
    for (int a = 0; a < 6; a++) sb.push_back({16'hA000 + 16'(a), 8'(a)});
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("stream_pc_enable", {31'd0, pc_enable}, 32'd1);
      check_output("stream_mem_addr", {24'd0, mem_addr}, i);
      check_output("stream_instr_valid", {31'd0, instr_valid}, (i >= 2) ? 32'd1 : 32'd0);
      next_cycle();
    end
    enable = 1'b0;
    drain("stream");

    // Backpressure: two issues then stall until the consumer is ready.
    apply_reset();
    for (int a = 0; a < 5; a++) sb.push_back({16'hA000 + 16'(a), 8'(a)});
    enable = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_mem_req", {31'd0, mem_req}, (i < 2) ? 32'd1 : 32'd0);
      next_cycle();
    end
    check_output("bp_pc_hold", {24'd0, pc}, 32'd2);
    check_output("bp_full_valid", {31'd0, instr_valid}, 32'd1);
    check_output("bp_head_pc", {24'd0, instr_pc}, 32'd0);
    out_ready = 1'b1;
    repeat (3) next_cycle();
    enable = 1'b0;
    drain("bp");

    // Flush with one entry buffered and one read in flight.
    apply_reset();
    sb.push_back({16'hA002, 8'h02});
    sb.push_back({16'hA003, 8'h03});
    enable = 1'b1; out_ready = 1'b0;
    repeat (2) next_cycle();
    flush = 1'b1;
    @(negedge clk);
    check_output("flush_no_issue", {31'd0, mem_req}, 32'd0);
    check_output("flush_no_pc_enable", {31'd0, pc_enable}, 32'd0);
    next_cycle();
    flush = 1'b0; enable = 1'b0;
    @(negedge clk);
    check_output("flush_instr_valid", {31'd0, instr_valid}, 32'd0);
    check_output("flush_busy", {31'd0, busy}, 32'd0);
    next_cycle();
    enable = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_output("flush_refetch_req", {31'd0, mem_req}, 32'd1);
    check_output("flush_refetch_addr", {24'd0, mem_addr}, 32'd2);
    next_cycle();
    next_cycle();
    enable = 1'b0;
    drain("flush");

    // Address wrap: FE, FF, 00 are fetched with no special handling.
    pc_load = 1'b1; pc_load_val = 8'hFE;
    next_cycle();
    pc_load = 1'b0;
    sb.push_back({16'hA0FE, 8'hFE});
    sb.push_back({16'hA0FF, 8'hFF});
    sb.push_back({16'hA000, 8'h00});
    enable = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("wrap_mem_addr", {24'd0, mem_addr}, 32'(8'(8'hFE + i)));
      check_output("wrap_pc_increment", {24'd0, pc_increment}, 32'd1);
      next_cycle();
    end
    enable = 1'b0;
    drain("wrap");

    // Enable gap: the pending response still lands.
    sb.push_back({16'hA001, 8'h01});
    enable = 1'b1;
    @(negedge clk);
    check_output("gap_issue", {31'd0, mem_req}, 32'd1);
    next_cycle();
    enable = 1'b0;
    @(negedge clk);
    check_output("gap_mem_req", {31'd0, mem_req}, 32'd0);
    check_output("gap_pc_enable", {31'd0, pc_enable}, 32'd0);
    check_output("gap_pc_increment", {24'd0, pc_increment}, 32'd0);
    check_output("gap_busy", {31'd0, busy}, 32'd1);
    next_cycle();
    drain("gap");

    // Asynchronous reset in the middle of an issue cycle.
    enable = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check_output("ar_pre_req", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check_output("ar_mem_req", {31'd0, mem_req}, 32'd0);
    check_output("ar_pc_enable", {31'd0, pc_enable}, 32'd0);
    check_output("ar_mem_addr", {24'd0, mem_addr}, 32'd0);
    check_output("ar_busy", {31'd0, busy}, 32'd0);
    check_output("ar_instr_valid", {31'd0, instr_valid}, 32'd0);
    next_cycle();
    next_cycle();
    sb.push_back({16'hA000, 8'h00});
    reset = 1'b1;
    @(negedge clk);
    check_output("ar_first_issue", {31'd0, mem_req}, 32'd1);
    check_output("ar_first_addr", {24'd0, mem_addr}, 32'd0);
    check_output("ar_no_late_push", {31'd0, instr_valid}, 32'd0);
    next_cycle();
    enable = 1'b0;
    drain("ar");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
